// File: rtl/wormhole_switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking: heads and singles
// arbitrate, and a head's winner keeps the output until its tail has crossed.
module wormhole_switch_allocator #(
    parameter int IN_N      = 5,
    parameter int OUT_M     = 5,
    parameter int FLIT_ID_W = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [IN_N-1:0]                     valid_i,
    input  logic [IN_N-1:0][FLIT_ID_W-1:0]      flit_id_i,
    input  logic [IN_N-1:0][OUT_M-1:0]          req_i,
    input  logic [OUT_M-1:0]                    out_rdy_i,
    output logic [OUT_M-1:0][IN_N-1:0]          sel_o,
    output logic [OUT_M-1:0]                    valid_o,
    output logic [IN_N-1:0]                     pop_o
);

    localparam int IDX_W = (IN_N > 1) ? $clog2(IN_N) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [FLIT_ID_W-1:0] FID_SINGLE = FLIT_ID_W'(0);
    localparam logic [FLIT_ID_W-1:0] FID_HEAD   = FLIT_ID_W'(1);
    localparam logic [FLIT_ID_W-1:0] FID_TAIL   = FLIT_ID_W'(3);

    logic [OUT_M-1:0]          lock_vld_q, lock_vld_d;
    idx_t [OUT_M-1:0]          lock_src_q, lock_src_d;
    idx_t [OUT_M-1:0]          rr_ptr_q,   rr_ptr_d;

    logic [OUT_M-1:0][IN_N-1:0] cand;
    logic [OUT_M-1:0]           grant_vld;
    idx_t [OUT_M-1:0]           grant_idx;

    // Index arithmetic modulo IN_N, which need not be a power of two.
    function automatic idx_t wrap_idx(input idx_t base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= IN_N) begin
            sum = sum - IN_N;
        end
        return idx_t'(sum);
    endfunction

    // Only heads and singles may compete for an unlocked output.
    always_comb begin
        cand = '0;
        for (int m = 0; m < OUT_M; m++) begin
            for (int i = 0; i < IN_N; i++) begin
                cand[m][i] = valid_i[i] && req_i[i][m] &&
                             ((flit_id_i[i] == FID_HEAD) || (flit_id_i[i] == FID_SINGLE));
            end
        end
    end

    always_comb begin
        grant_vld = '0;
        grant_idx = '0;
        for (int m = 0; m < OUT_M; m++) begin
            for (int k = 0; k < IN_N; k++) begin
                if (!grant_vld[m] && cand[m][wrap_idx(rr_ptr_q[m], k)]) begin
                    grant_vld[m] = 1'b1;
                    grant_idx[m] = wrap_idx(rr_ptr_q[m], k);
                end
            end
        end
    end

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_src_d = lock_src_q;
        rr_ptr_d   = rr_ptr_q;
        sel_o      = '0;
        pop_o      = '0;
        for (int m = 0; m < OUT_M; m++) begin
            if (lock_vld_q[m]) begin
                if (valid_i[lock_src_q[m]] && out_rdy_i[m]) begin
                    sel_o[m][lock_src_q[m]] = 1'b1;
                    pop_o[lock_src_q[m]]    = 1'b1;
                    if (flit_id_i[lock_src_q[m]] == FID_TAIL) begin
                        lock_vld_d[m] = 1'b0;
                    end
                end
            end else if (out_rdy_i[m] && grant_vld[m]) begin
                sel_o[m][grant_idx[m]] = 1'b1;
                pop_o[grant_idx[m]]    = 1'b1;
                rr_ptr_d[m]            = wrap_idx(grant_idx[m], 1);
                if (flit_id_i[grant_idx[m]] == FID_HEAD) begin
                    lock_vld_d[m] = 1'b1;
                    lock_src_d[m] = grant_idx[m];
                end
            end
        end
        if (rst_i) begin
            sel_o = '0;
            pop_o = '0;
        end
    end

    always_comb begin
        valid_o = '0;
        for (int m = 0; m < OUT_M; m++) begin
            valid_o[m] = |sel_o[m];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_vld_q <= '0;
            lock_src_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_src_q <= lock_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Bench for wormhole_switch_allocator: directed vector table, hand-written
// wormhole/backpressure/reset sequences, then randomized packets against a model.
module tb_wormhole_switch_allocator;

    localparam int IN_N  = 5;
    localparam int OUT_M = 5;
    localparam int FW    = 2;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic [IN_N-1:0]              valid_i;
    logic [IN_N-1:0][FW-1:0]      flit_id_i;
    logic [IN_N-1:0][OUT_M-1:0]   req_i;
    logic [OUT_M-1:0]             out_rdy_i;
    logic [OUT_M-1:0][IN_N-1:0]   sel_o;
    logic [OUT_M-1:0]             valid_o;
    logic [IN_N-1:0]              pop_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit               rst;
        int               dest[IN_N];
        int               fid[IN_N];
        bit [IN_N-1:0]    valid;
        bit [OUT_M-1:0]   rdy;
        int               exp_src[OUT_M];
    } vec_t;

    vec_t tbl[$];

    // Reference model state for the random phase.
    int m_lock_vld[OUT_M];
    int m_lock_src[OUT_M];
    int m_ptr[OUT_M];
    int g_dest[IN_N];
    int g_len[IN_N];
    int g_pos[IN_N];

    wormhole_switch_allocator #(
        .IN_N      (IN_N),
        .OUT_M     (OUT_M),
        .FLIT_ID_W (FW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .flit_id_i (flit_id_i),
        .req_i     (req_i),
        .out_rdy_i (out_rdy_i),
        .sel_o     (sel_o),
        .valid_o   (valid_o),
        .pop_o     (pop_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mkVec(input bit rst, input int d[IN_N], input int f[IN_N],
                                   input bit [IN_N-1:0] v, input bit [OUT_M-1:0] r,
                                   input int e[OUT_M]);
        vec_t x;
        x.rst     = rst;
        x.dest    = d;
        x.fid     = f;
        x.valid   = v;
        x.rdy     = r;
        x.exp_src = e;
        return x;
    endfunction

    task automatic applyStimulus(input bit rst, input int dest[IN_N], input int fid[IN_N],
                                 input bit [IN_N-1:0] valid, input bit [OUT_M-1:0] rdy);
        @(posedge clk_i);
        #1;
        rst_i     = rst;
        valid_i   = valid;
        out_rdy_i = rdy;
        for (int i = 0; i < IN_N; i++) begin
            req_i[i] = '0;
            if (dest[i] >= 0) req_i[i][dest[i]] = 1'b1;
            flit_id_i[i] = FW'(fid[i]);
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input int exp_src[OUT_M]);
        logic [OUT_M-1:0][IN_N-1:0] esel;
        logic [OUT_M-1:0]           evld;
        logic [IN_N-1:0]            epop;
        esel = '0;
        evld = '0;
        epop = '0;
        for (int m = 0; m < OUT_M; m++) begin
            if (exp_src[m] >= 0) begin
                esel[m][exp_src[m]] = 1'b1;
                evld[m]             = 1'b1;
                epop[exp_src[m]]    = 1'b1;
            end
        end
        checks++;
        if (sel_o !== esel) begin
            errors++;
            $display("[TB] FAIL %s sel_o got %h want %h", name, sel_o, esel);
        end
        checks++;
        if (valid_o !== evld) begin
            errors++;
            $display("[TB] FAIL %s valid_o got %b want %b", name, valid_o, evld);
        end
        checks++;
        if (pop_o !== epop) begin
            errors++;
            $display("[TB] FAIL %s pop_o got %b want %b", name, pop_o, epop);
        end
    endtask

    task automatic step(input string name, input bit rst, input int dest[IN_N],
                        input int fid[IN_N], input bit [IN_N-1:0] valid,
                        input bit [OUT_M-1:0] rdy, input int exp_src[OUT_M]);
        applyStimulus(rst, dest, fid, valid, rdy);
        checkOutput(name, exp_src);
    endtask

    task automatic newPacket(input int i);
        g_dest[i] = int'($urandom_range(0, OUT_M - 1));
        g_len[i]  = int'($urandom_range(1, 4));
        g_pos[i]  = 0;
    endtask

    function automatic int genFid(input int i);
        if (g_len[i] == 1)            return 0;
        if (g_pos[i] == 0)            return 1;
        if (g_pos[i] == g_len[i] - 1) return 3;
        return 2;
    endfunction

    initial begin
        int d[IN_N];
        int f[IN_N];
        int e[OUT_M];
        bit [IN_N-1:0]  v;
        bit [OUT_M-1:0] r;
        bit rs;
        int popped[IN_N];

        rst_i     = 1'b1;
        valid_i   = '0;
        flit_id_i = '0;
        req_i     = '0;
        out_rdy_i = '0;

        // Reset with everything valid, then fairness on output 1, then parallel packets.
        tbl.push_back(mkVec(1, '{0,0,0,0,0}, '{0,0,0,0,0}, 5'b11111, 5'b11111, '{-1,-1,-1,-1,-1}));
        tbl.push_back(mkVec(1, '{0,0,0,0,0}, '{0,0,0,0,0}, 5'b11111, 5'b11111, '{-1,-1,-1,-1,-1}));
        tbl.push_back(mkVec(0, '{0,0,0,0,0}, '{0,0,0,0,0}, 5'b11111, 5'b11111, '{0,-1,-1,-1,-1}));
        tbl.push_back(mkVec(0, '{1,-1,1,-1,1}, '{0,0,0,0,0}, 5'b10101, 5'b11111, '{-1,0,-1,-1,-1}));
        tbl.push_back(mkVec(0, '{1,-1,1,-1,1}, '{0,0,0,0,0}, 5'b10101, 5'b11111, '{-1,2,-1,-1,-1}));
        tbl.push_back(mkVec(0, '{1,-1,1,-1,1}, '{0,0,0,0,0}, 5'b10101, 5'b11111, '{-1,4,-1,-1,-1}));
        tbl.push_back(mkVec(0, '{1,-1,1,-1,1}, '{0,0,0,0,0}, 5'b10101, 5'b11111, '{-1,0,-1,-1,-1}));
        tbl.push_back(mkVec(0, '{1,-1,1,-1,1}, '{0,0,0,0,0}, 5'b10101, 5'b11111, '{-1,2,-1,-1,-1}));
        tbl.push_back(mkVec(0, '{4,3,2,1,0}, '{1,1,1,1,1}, 5'b11111, 5'b11111, '{4,3,2,1,0}));
        tbl.push_back(mkVec(0, '{4,3,2,1,0}, '{2,2,2,2,2}, 5'b11111, 5'b11111, '{4,3,2,1,0}));
        tbl.push_back(mkVec(0, '{4,3,2,1,0}, '{3,3,3,3,3}, 5'b11111, 5'b11111, '{4,3,2,1,0}));

        for (int n = 0; n < tbl.size(); n++) begin
            step($sformatf("table[%0d]", n), tbl[n].rst, tbl[n].dest, tbl[n].fid,
                 tbl[n].valid, tbl[n].rdy, tbl[n].exp_src);
        end

        // Wormhole lock: pointer moved to 2, input 3 beats input 1 and holds output 0.
        step("lockRst", 1, '{-1,-1,-1,-1,-1}, '{0,0,0,0,0}, 5'b00000, 5'b11111, '{-1,-1,-1,-1,-1});
        step("lockPtr", 0, '{-1,0,-1,-1,-1}, '{0,0,0,0,0}, 5'b00010, 5'b11111, '{1,-1,-1,-1,-1});
        step("lockHead", 0, '{-1,0,-1,0,-1}, '{0,1,0,1,0}, 5'b01010, 5'b11111, '{3,-1,-1,-1,-1});
        step("lockBody1", 0, '{-1,0,-1,0,-1}, '{0,1,0,2,0}, 5'b01010, 5'b11111, '{3,-1,-1,-1,-1});
        step("lockBody2", 0, '{-1,0,-1,0,-1}, '{0,1,0,2,0}, 5'b01010, 5'b11111, '{3,-1,-1,-1,-1});
        step("lockTail", 0, '{-1,0,-1,0,-1}, '{0,1,0,3,0}, 5'b01010, 5'b11111, '{3,-1,-1,-1,-1});
        step("lockNext", 0, '{-1,0,-1,0,-1}, '{0,1,0,0,0}, 5'b00010, 5'b11111, '{1,-1,-1,-1,-1});
        step("lockNextTail", 0, '{-1,0,-1,-1,-1}, '{0,3,0,0,0}, 5'b00010, 5'b11111, '{1,-1,-1,-1,-1});

        // Backpressure and bubble on a locked output 2; input 0 must wait.
        step("bpHead", 0, '{-1,-1,2,-1,-1}, '{0,0,1,0,0}, 5'b00100, 5'b11111, '{-1,-1,2,-1,-1});
        step("bpRdy0", 0, '{2,-1,2,-1,-1}, '{1,0,2,0,0}, 5'b00101, 5'b11011, '{-1,-1,-1,-1,-1});
        step("bpRdy1", 0, '{2,-1,2,-1,-1}, '{1,0,2,0,0}, 5'b00101, 5'b11011, '{-1,-1,-1,-1,-1});
        step("bpBubble", 0, '{2,-1,2,-1,-1}, '{1,0,2,0,0}, 5'b00001, 5'b11111, '{-1,-1,-1,-1,-1});
        step("bpBody", 0, '{2,-1,2,-1,-1}, '{1,0,2,0,0}, 5'b00101, 5'b11111, '{-1,-1,2,-1,-1});
        step("bpTail", 0, '{2,-1,2,-1,-1}, '{1,0,3,0,0}, 5'b00101, 5'b11111, '{-1,-1,2,-1,-1});
        step("bpWaiter", 0, '{2,-1,-1,-1,-1}, '{1,0,0,0,0}, 5'b00001, 5'b11111, '{-1,-1,0,-1,-1});
        step("bpWaiterTail", 0, '{2,-1,-1,-1,-1}, '{3,0,0,0,0}, 5'b00001, 5'b11111, '{-1,-1,0,-1,-1});

        // Reset mid-packet drops the lock on output 3.
        step("mrHead", 0, '{-1,-1,-1,-1,3}, '{0,0,0,0,1}, 5'b10000, 5'b11111, '{-1,-1,-1,4,-1});
        step("mrBody", 0, '{-1,-1,-1,-1,3}, '{0,0,0,0,2}, 5'b10000, 5'b11111, '{-1,-1,-1,4,-1});
        step("mrReset", 1, '{-1,3,-1,-1,3}, '{0,1,0,0,2}, 5'b10010, 5'b11111, '{-1,-1,-1,-1,-1});
        step("mrNewHead", 0, '{-1,3,-1,-1,-1}, '{0,1,0,0,0}, 5'b00010, 5'b11111, '{-1,-1,-1,1,-1});
        step("mrNewTail", 0, '{-1,3,-1,-1,-1}, '{0,3,0,0,0}, 5'b00010, 5'b11111, '{-1,-1,-1,1,-1});

        // Randomized packet traffic against the reference model.
        for (int i = 0; i < IN_N; i++) newPacket(i);
        for (int m = 0; m < OUT_M; m++) begin
            m_lock_vld[m] = 0;
            m_lock_src[m] = 0;
            m_ptr[m]      = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rs = (cyc == 0) || ($urandom_range(0, 149) == 0);
            for (int i = 0; i < IN_N; i++) begin
                d[i] = g_dest[i];
                f[i] = genFid(i);
                v[i] = ($urandom_range(0, 3) != 0);
            end
            for (int m = 0; m < OUT_M; m++) begin
                r[m] = ($urandom_range(0, 4) != 0);
                e[m] = -1;
                if (!rs) begin
                    if (m_lock_vld[m] != 0) begin
                        if (v[m_lock_src[m]] && r[m]) e[m] = m_lock_src[m];
                    end else if (r[m]) begin
                        int best_dist;
                        best_dist = IN_N;
                        for (int i = 0; i < IN_N; i++) begin
                            if (v[i] && d[i] == m && (f[i] == 0 || f[i] == 1) &&
                                ((i - m_ptr[m] + IN_N) % IN_N) < best_dist) begin
                                best_dist = (i - m_ptr[m] + IN_N) % IN_N;
                                e[m] = i;
                            end
                        end
                    end
                end
            end
            step($sformatf("rand[%0d]", cyc), rs, d, f, v, r, e);

            for (int i = 0; i < IN_N; i++) popped[i] = 0;
            if (rs) begin
                for (int m = 0; m < OUT_M; m++) begin
                    m_lock_vld[m] = 0;
                    m_lock_src[m] = 0;
                    m_ptr[m]      = 0;
                end
                for (int i = 0; i < IN_N; i++) newPacket(i);
            end else begin
                for (int m = 0; m < OUT_M; m++) begin
                    if (e[m] >= 0) begin
                        popped[e[m]] = 1;
                        if (m_lock_vld[m] != 0) begin
                            if (f[e[m]] == 3) m_lock_vld[m] = 0;
                        end else begin
                            m_ptr[m] = (e[m] + 1) % IN_N;
                            if (f[e[m]] == 1) begin
                                m_lock_vld[m] = 1;
                                m_lock_src[m] = e[m];
                            end
                        end
                    end
                end
                for (int i = 0; i < IN_N; i++) begin
                    if (popped[i] != 0) begin
                        g_pos[i]++;
                        if (g_pos[i] >= g_len[i]) newPacket(i);
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wormhole_switch_allocator.md
# wormhole_switch_allocator

Per-output round-robin switch allocator with wormhole packet locking. It sits directly upstream of the parallel crossbar and drives its per-output one-hot select bus. It also pops the input-channel FIFOs and marks valid flits on the output links. Arbitration happens only on head flits; an output then stays locked to the winning input until that packet's tail flit has been transferred.

## Interface
- IN_N, 5: number of input channels.
- OUT_M, 5: number of output channels.
- FLIT_ID_W, 2: width of the flit-ID field. Encoding: 2'b01 head, 2'b10 body, 2'b11 tail, 2'b00 single (head+tail).

Ports:
- clk_i, in, 1: the single clock; all state updates on its rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- valid_i, in, IN_N: input FIFO not empty; the flit at the head is presented.
- flit_id_i, in, IN_N×FLIT_ID_W: ID of each presented flit.
- req_i, in, IN_N×OUT_M: one-hot requested output per input, from route computation. Held constant for the whole packet.
- out_rdy_i, in, OUT_M: downstream of output m can accept a flit this cycle.
- sel_o, out, OUT_M×IN_N: one-hot crossbar select per output; all-zero when that output has no transfer.
- valid_o, out, OUT_M: flit on output m valid this cycle (equals OR of sel_o[m]).
- pop_o, out, IN_N: dequeue input i this cycle.

## Operation
- Per-output state: lock_vld[m], lock_src[m] (input index), rr_ptr[m] (input index of highest priority).
- Output m is **unlocked**:
  - Candidates are inputs i with valid_i[i], req_i[i][m], and a flit_id of head or single.
  - If out_rdy_i[m] is high and any candidate exists, grant the first candidate searching i = rr_ptr[m], rr_ptr[m]+1, …, wrapping modulo IN_N.
  - For the granted input i: sel_o[m] = one-hot(i), pop_o[i] = 1, and rr_ptr[m] is set to (i+1) mod IN_N.
  - If the granted flit is a head, set lock_vld[m] = 1 and lock_src[m] = i. If it is a single, the output stays unlocked.
- Output m is **locked** to input s:
  - Only s may use output m; requests from other inputs for m are ignored.
  - If valid_i[s] and out_rdy_i[m]: sel_o[m] = one-hot(s), pop_o[s] = 1, and the flit is forwarded whatever its ID.
  - If the forwarded flit is a tail, clear lock_vld[m]. rr_ptr[m] is unchanged.
  - If valid_i[s] is low or out_rdy_i[m] is low, sel_o[m] = 0 and the lock is held (bubble).
- req_i is one-hot, so each input is granted by at most one output per cycle and pop_o is well defined.
- A head or single flit that is not granted stays in its FIFO (pop_o = 0) and retries the next cycle.
- An input whose head flit targets an output locked by another input waits; the lock-owner's packet is not preempted.
- Flit IDs that violate protocol (body or tail arriving at an unlocked output) are not candidates and are never popped. Flagging this is the upstream's responsibility.

## Timing
- sel_o, valid_o, and pop_o are combinational from the current inputs and the registered state. A flit crosses the crossbar in the same cycle it is popped, so allocation adds zero latency.
- Lock, source, and pointer updates take effect on the next rising edge. A head granted in cycle t lets the same input's body flit go out in cycle t+1.
- A single flit, or a tail, releases the output in the same cycle it is transferred. A new head can win that output in the next cycle.
- Reset:
  - While rst_i is high, sel_o, valid_o, and pop_o are forced to 0.
  - At the next edge, lock_vld = 0, lock_src = 0, and rr_ptr = 0.
  - Reset asserted mid-packet drops the lock. Upstream FIFOs are reset together with the allocator.
- Throughput: one flit per output per cycle. Up to min(IN_N, OUT_M) flits move per cycle when there is no output contention.

## Test plan
1. **Reset.** Drive all valid_i high and rst_i high for 2 cycles -> sel_o, valid_o, and pop_o stay 0. After release, rr_ptr=0, so input 0 wins first.
2. **Round-robin fairness.** Inputs 0, 2, and 4 each present repeated single flits to output 1, with out_rdy_i[1]=1 -> grants go 0, 2, 4, 0, 2, … on consecutive cycles, and sel_o[1] cycles through 5'b00001, 5'b00100, 5'b10000.
3. **Wormhole lock.** Input 3 sends a head, two bodies, and a tail to output 0. Input 1 presents a head for output 0 in the same cycle as input 3's head -> input 3 wins (rr_ptr=0 and 3 is searched first only if input 1 is absent; set rr_ptr to 2 beforehand). Output 0 stays 5'b01000 for 4 cycles, and input 1 is granted in cycle 5.
4. **Backpressure and bubble.** While a packet is locked on output 2, drop out_rdy_i[2] for 2 cycles and then valid_i for 1 cycle -> sel_o[2]=0 and pop_o=0 in those cycles. The lock is kept, and the tail releases it afterwards.
5. **Parallel traffic.** Inputs 0→4, 1→3, 2→2, 3→1, and 4→0 run concurrently with all outputs ready -> five transfers per cycle, and pop_o=5'b11111.
6. **Reset mid-packet.** Assert rst_i after a head and one body -> the lock clears. A subsequent head from a different input wins that output immediately.
